// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle Moore control FSM for the MIPS-subset datapath.
// Define MC_CTRL_MULDIV_EN to add mult/div/mfhi/mflo decode, the MDWAIT state and its stall counter.
module mc_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [2:0]  compare,
  output logic        PCWr,
  output logic        IRWr,
  output logic        regwe,
  output logic        memwe,
  output logic        alusrc,
  output logic        validbr,
  output logic        turn,
  output logic [1:0]  regdst,
  output logic [2:0]  memtoreg,
  output logic [2:0]  jump,
  output logic [1:0]  extop,
  output logic [3:0]  aluop,
  output logic        illegal
);

  typedef enum logic [3:0] {
    S_INIT, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_JREG, S_MDWAIT
  } state_t;

  typedef enum logic [3:0] {
    K_ILL, K_LOAD, K_STORE, K_RALU, K_IALU, K_BR, K_J, K_JAL, K_JR,
    K_MUL, K_DIV, K_MFHI, K_MFLO
  } kind_t;

  state_t      state_q, state_d;
  kind_t       kind_s;
  logic [3:0]  alu_s;
  logic        br_taken_s;
  logic [5:0]  op_s, funct_s;
  logic [4:0]  rt_s;
  logic        unused_s;

  assign op_s    = instr[31:26];
  assign funct_s = instr[5:0];
  assign rt_s    = instr[20:16];

`ifdef MC_CTRL_MULDIV_EN
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);
  logic [5:0] cnt_q, cnt_d;
  assign unused_s = ^{instr[25:21], instr[15:6]};
`else
  assign unused_s = ^{instr[25:21], instr[15:6], MUL_CYCLES[0], DIV_CYCLES[0]};
`endif

  // Instruction classification and the ALU operation used in EXEC
  always_comb begin
    kind_s = K_ILL;
    alu_s  = 4'h0;
    case (op_s)
      6'h00: begin
        case (funct_s)
          6'h00: begin kind_s = K_RALU; alu_s = 4'h8; end
          6'h02: begin kind_s = K_RALU; alu_s = 4'h9; end
          6'h03: begin kind_s = K_RALU; alu_s = 4'hA; end
          6'h08: kind_s = K_JR;
`ifdef MC_CTRL_MULDIV_EN
          6'h10: kind_s = K_MFHI;
          6'h12: kind_s = K_MFLO;
          6'h18, 6'h19: kind_s = K_MUL;
          6'h1A, 6'h1B: kind_s = K_DIV;
`endif
          6'h20, 6'h21: begin kind_s = K_RALU; alu_s = 4'h0; end
          6'h22, 6'h23: begin kind_s = K_RALU; alu_s = 4'h1; end
          6'h24: begin kind_s = K_RALU; alu_s = 4'h2; end
          6'h25: begin kind_s = K_RALU; alu_s = 4'h3; end
          6'h26: begin kind_s = K_RALU; alu_s = 4'h4; end
          6'h27: begin kind_s = K_RALU; alu_s = 4'h5; end
          6'h2A: begin kind_s = K_RALU; alu_s = 4'h6; end
          6'h2B: begin kind_s = K_RALU; alu_s = 4'h7; end
          default: kind_s = K_ILL;
        endcase
      end
      6'h01: begin
        if (rt_s == 5'd0 || rt_s == 5'd1) kind_s = K_BR;
        else                              kind_s = K_ILL;
      end
      6'h02: kind_s = K_J;
      6'h03: kind_s = K_JAL;
      6'h04, 6'h05, 6'h06, 6'h07: kind_s = K_BR;
      6'h08, 6'h09: begin kind_s = K_IALU; alu_s = 4'h0; end
      6'h0A: begin kind_s = K_IALU; alu_s = 4'h6; end
      6'h0B: begin kind_s = K_IALU; alu_s = 4'h7; end
      6'h0C: begin kind_s = K_IALU; alu_s = 4'h2; end
      6'h0D: begin kind_s = K_IALU; alu_s = 4'h3; end
      6'h0E: begin kind_s = K_IALU; alu_s = 4'h4; end
      6'h0F: begin kind_s = K_IALU; alu_s = 4'hB; end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: kind_s = K_LOAD;
      6'h28, 6'h29, 6'h2B: kind_s = K_STORE;
      default: kind_s = K_ILL;
    endcase
  end

  // Branch condition from {zero, more, notless}; REGIMM rt[0] selects bgez over bltz
  always_comb begin
    case (op_s)
      6'h01:   br_taken_s = rt_s[0] ? compare[0] : ~compare[0];
      6'h04:   br_taken_s = compare[2];
      6'h05:   br_taken_s = ~compare[2];
      6'h06:   br_taken_s = ~compare[1];
      6'h07:   br_taken_s = compare[1];
      default: br_taken_s = 1'b0;
    endcase
  end

  // State register and stall counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
`ifdef MC_CTRL_MULDIV_EN
      cnt_q   <= 6'd0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MC_CTRL_MULDIV_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Next state and Moore outputs
  always_comb begin
    state_d  = state_q;
`ifdef MC_CTRL_MULDIV_EN
    cnt_d    = cnt_q;
`endif
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    regwe    = 1'b0;
    memwe    = 1'b0;
    alusrc   = 1'b0;
    validbr  = 1'b0;
    turn     = 1'b0;
    regdst   = 2'b00;
    memtoreg = 3'b000;
    jump     = 3'b000;
    extop    = 2'b00;
    aluop    = 4'h0;
    illegal  = 1'b0;
    case (state_q)
      S_INIT:  state_d = S_FETCH;
      S_FETCH: begin
        PCWr    = 1'b1;
        IRWr    = 1'b1;
        turn    = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (kind_s)
          K_LOAD, K_STORE:      state_d = S_MEMADR;
          K_RALU, K_IALU, K_JR: state_d = S_EXEC;
          K_BR:                 state_d = S_BRANCH;
          K_J, K_JAL:           state_d = S_JUMP;
`ifdef MC_CTRL_MULDIV_EN
          K_MUL: begin state_d = S_MDWAIT; cnt_d = MUL_LOAD; end
          K_DIV: begin state_d = S_MDWAIT; cnt_d = DIV_LOAD; end
          K_MFHI, K_MFLO:       state_d = S_ALUWB;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrc  = 1'b1;
        extop   = 2'b01;
        state_d = (kind_s == K_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMWR: begin
        memwe   = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMRD: state_d = S_MEMWB;
      S_MEMWB: begin
        regwe    = 1'b1;
        memtoreg = 3'b001;
        state_d  = S_FETCH;
      end
      S_EXEC: begin
        aluop  = alu_s;
        alusrc = (kind_s == K_IALU);
        if (op_s == 6'h0C || op_s == 6'h0D || op_s == 6'h0E) extop = 2'b00;
        else if (op_s == 6'h0F)                               extop = 2'b10;
        else                                                  extop = 2'b01;
        state_d = (kind_s == K_JR) ? S_JREG : S_ALUWB;
      end
      S_ALUWB: begin
        regwe  = 1'b1;
        regdst = (kind_s == K_IALU) ? 2'b00 : 2'b01;
`ifdef MC_CTRL_MULDIV_EN
        if (kind_s == K_MFHI)      memtoreg = 3'b011;
        else if (kind_s == K_MFLO) memtoreg = 3'b100;
        else                       memtoreg = 3'b000;
`endif
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        aluop   = 4'h1;
        jump    = 3'b001;
        validbr = br_taken_s;
        PCWr    = br_taken_s;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        PCWr = 1'b1;
        jump = 3'b010;
        if (kind_s == K_JAL) begin
          regwe    = 1'b1;
          regdst   = 2'b10;
          memtoreg = 3'b010;
        end else begin
          regwe    = 1'b0;
        end
        state_d = S_FETCH;
      end
      S_JREG: begin
        PCWr    = 1'b1;
        jump    = 3'b011;
        state_d = S_FETCH;
      end
`ifdef MC_CTRL_MULDIV_EN
      // Counter was preloaded with N-1 on entry, so exactly N cycles are spent here
      S_MDWAIT: begin
        if (cnt_q == 6'd0) state_d = S_FETCH;
        else               cnt_d   = cnt_q - 6'd1;
      end
`endif
      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed checks of mc_ctrl state outputs, instruction by instruction.
// Mult/div checks follow MC_CTRL_MULDIV_EN; otherwise those encodings are checked as illegal.
module tb_mc_ctrl;
  logic        clk, rst;
  logic [31:0] instr;
  logic [2:0]  compare;
  logic        PCWr, IRWr, regwe, memwe, alusrc, validbr, turn, illegal;
  logic [1:0]  regdst, extop;
  logic [2:0]  memtoreg, jump;
  logic [3:0]  aluop;
  int          errors = 0;
  int          checks = 0;
  logic [21:0] e_fetch, e_zero;

  mc_ctrl #(.MUL_CYCLES(5), .DIV_CYCLES(34)) dut (
    .clk(clk), .rst(rst), .instr(instr), .compare(compare),
    .PCWr(PCWr), .IRWr(IRWr), .regwe(regwe), .memwe(memwe), .alusrc(alusrc),
    .validbr(validbr), .turn(turn), .regdst(regdst), .memtoreg(memtoreg),
    .jump(jump), .extop(extop), .aluop(aluop), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word: {PCWr,IRWr,regwe,memwe,alusrc,validbr,turn,illegal,regdst,memtoreg,jump,extop,aluop}
  function automatic logic [21:0] ev(input logic pcwr, input logic irwr, input logic rwe,
                                     input logic mwe, input logic asrc, input logic vbr,
                                     input logic trn, input logic ill, input logic [1:0] rdst,
                                     input logic [2:0] m2r, input logic [2:0] jmp,
                                     input logic [1:0] ext, input logic [3:0] aop);
    return {pcwr, irwr, rwe, mwe, asrc, vbr, trn, ill, rdst, m2r, jmp, ext, aop};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [21:0] exp);
    logic [21:0] obs;
    obs = {PCWr, IRWr, regwe, memwe, alusrc, validbr, turn, illegal,
           regdst, memtoreg, jump, extop, aluop};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the FETCH cycle, then present the next instruction for DECODE
  task automatic fetch(input string tag, input logic [31:0] ins);
    chk({tag, " fetch"}, e_fetch);
    instr = ins;
    tick();
  endtask

  initial begin
    e_zero  = 22'h0;
    e_fetch = ev(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 3'b000, 2'b00, 4'h0);
    rst     = 1'b0;
    instr   = 32'hFFFF_FFFF;
    compare = 3'b000;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset held", e_zero);
    end
    rst = 1'b1;
    #1 chk("init after release", e_zero);
    tick();

    fetch("addu", 32'h0022_1821);
    chk("addu decode", e_zero); tick();
    chk("addu exec", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,3'b000,2'b01,4'h0)); tick();
    chk("addu aluwb", ev(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,3'b000,2'b00,4'h0)); tick();

    fetch("lw", 32'h8C04_0004);
    chk("lw decode", e_zero); tick();
    chk("lw memadr", ev(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,3'b000,3'b000,2'b01,4'h0)); tick();
    chk("lw memrd", e_zero); tick();
    chk("lw memwb", ev(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b001,3'b000,2'b00,4'h0)); tick();

    fetch("sw", 32'hAC04_0008);
    chk("sw decode", e_zero); tick();
    chk("sw memadr", ev(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,3'b000,3'b000,2'b01,4'h0)); tick();
    chk("sw memwr", ev(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,3'b000,2'b00,4'h0)); tick();

    fetch("ori", 32'h3422_0005);
    chk("ori decode", e_zero); tick();
    chk("ori exec", ev(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,3'b000,3'b000,2'b00,4'h3)); tick();
    chk("ori aluwb", ev(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,3'b000,2'b00,4'h0)); tick();

    fetch("lui", 32'h3C01_1234);
    chk("lui decode", e_zero); tick();
    chk("lui exec", ev(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,3'b000,3'b000,2'b10,4'hB)); tick();
    chk("lui aluwb", ev(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,3'b000,2'b00,4'h0)); tick();

    compare = 3'b100;
    fetch("beq", 32'h1022_0003);
    chk("beq decode", e_zero); tick();
    chk("beq taken", ev(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,3'b001,2'b00,4'h1)); tick();
    fetch("bne", 32'h1422_0003);
    chk("bne decode", e_zero); tick();
    chk("bne not taken", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,3'b001,2'b00,4'h1)); tick();
    compare = 3'b010;
    fetch("bgtz", 32'h1C20_0003);
    chk("bgtz decode", e_zero); tick();
    chk("bgtz taken", ev(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,3'b001,2'b00,4'h1)); tick();
    compare = 3'b011;
    fetch("bltz", 32'h0420_0003);
    chk("bltz decode", e_zero); tick();
    chk("bltz not taken", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,3'b001,2'b00,4'h1)); tick();
    fetch("bgez", 32'h0421_0003);
    chk("bgez decode", e_zero); tick();
    chk("bgez taken", ev(1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,3'b000,3'b001,2'b00,4'h1)); tick();
    compare = 3'b000;

    fetch("jal", 32'h0C00_0040);
    chk("jal decode", e_zero); tick();
    chk("jal jump", ev(1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,3'b010,3'b010,2'b00,4'h0)); tick();
    fetch("jr", 32'h03E0_0008);
    chk("jr decode", e_zero); tick();
    chk("jr exec", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,3'b000,2'b01,4'h0)); tick();
    chk("jr jreg", ev(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,3'b011,2'b00,4'h0)); tick();

    fetch("op3f", 32'hFC00_0000);
    chk("op3f illegal", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b000,3'b000,2'b00,4'h0)); tick();

`ifdef MC_CTRL_MULDIV_EN
    fetch("mfhi", 32'h0000_1810);
    chk("mfhi decode", e_zero); tick();
    chk("mfhi aluwb", ev(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b011,3'b000,2'b00,4'h0)); tick();
    fetch("mflo", 32'h0000_1812);
    chk("mflo decode", e_zero); tick();
    chk("mflo aluwb", ev(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b100,3'b000,2'b00,4'h0)); tick();

    fetch("mult", 32'h0022_0018);
    chk("mult decode", e_zero); tick();
    for (int i = 0; i < 5; i++) begin chk("mult wait", e_zero); tick(); end
    fetch("div", 32'h0022_001A);
    chk("div decode", e_zero); tick();
    for (int i = 0; i < 34; i++) begin chk("div wait", e_zero); tick(); end
    fetch("div abort", 32'h0022_001B);
    chk("div abort decode", e_zero); tick();
    for (int i = 0; i < 23; i++) begin chk("div abort wait", e_zero); tick(); end
    rst = 1'b0;
    #1 chk("reset mid mdwait", e_zero);
    tick();
    chk("reset held mdwait", e_zero);
    rst = 1'b1;
    #1 chk("init after mdwait abort", e_zero);
    tick();
    fetch("multu", 32'h0022_0019);
    chk("multu decode", e_zero); tick();
    for (int i = 0; i < 5; i++) begin chk("multu wait", e_zero); tick(); end
`else
    fetch("mfhi off", 32'h0000_1810);
    chk("mfhi off illegal", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b000,3'b000,2'b00,4'h0)); tick();
    fetch("mult off", 32'h0022_0018);
    chk("mult off illegal", ev(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b000,3'b000,2'b00,4'h0)); tick();
`endif
    chk("final fetch", e_fetch);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
